// File: rtl/l1d_resp_pkg.sv
// Shared types and default geometry for the L1D lower-level responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package l1d_resp_pkg;
    localparam int LINE_BYTES  = 64;
    localparam int PADDR_W     = 22;
    localparam int NUM_LINES   = 64;
    localparam int OFFSET_BITS = $clog2(LINE_BYTES);
    localparam int INDEX_BITS  = $clog2(NUM_LINES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    typedef struct packed {
        logic [PADDR_W-1:0] paddr;
    } line_req_t;
endpackage

// File: rtl/line_req_fifo.sv
// Circular FIFO of pending line reads with registered full/empty/count.
// Latency: a push is visible at the head one cycle later; push and pop may share an edge.
// Backpressure: pushes while full are dropped unless a pop happens on the same edge.
// Ports: clk/rst (sync, active-high), push/push_data, pop, head, full, empty, count.
module line_req_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_nxt;

    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign count_nxt = count + CW'(do_push) - CW'(do_pop);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/l1d_lower_responder.sv
// Simplified L2 for the L1D miss path: write-backs land in a line store, reads return whole lines in order.
// Latency: a read accepted into an idle, empty responder is offered LATENCY+1 edges later.
// Backpressure: hc_ready_out drops while QUEUE_DEPTH reads are pending; a response is held until hc_ready_in.
// Ports: clk_in/rst_in (sync, active-high); request hc_valid_in/hc_ready_out/hc_addr_in/hc_value_in/hc_we_in;
//        response hc_valid_out/hc_ready_in/hc_addr_out/hc_value_out; err_out sticky misalignment flag.
// Optional: L1D_RESP_ALIGN_CHECK_EN builds the misaligned-read check driving err_out (otherwise tied 0).
module l1d_lower_responder
    import l1d_resp_pkg::*;
#(
    parameter int B           = LINE_BYTES,
    parameter int PADDR_BITS  = PADDR_W,
    parameter int LINES       = NUM_LINES,
    parameter int LATENCY     = 4,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  hc_valid_in,
    output logic                  hc_ready_out,
    input  logic [PADDR_BITS-1:0] hc_addr_in,
    input  logic [8*B-1:0]        hc_value_in,
    input  logic                  hc_we_in,
    output logic                  hc_valid_out,
    input  logic                  hc_ready_in,
    output logic [PADDR_BITS-1:0] hc_addr_out,
    output logic [8*B-1:0]        hc_value_out,
    output logic                  err_out
);
    localparam int OFF_W = $clog2(B);
    localparam int IDX_W = $clog2(LINES);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam int QC_W  = $clog2(QUEUE_DEPTH) + 1;

    resp_state_t       state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              pop;
    logic              push;
    logic              wr;
    line_req_t         push_req;
    line_req_t         head_req;
    logic              q_full;
    logic              q_empty;
    logic [QC_W-1:0]   q_count;
    logic [QC_W-1:0]   q_count_nxt;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  head_idx;
    logic [8*B-1:0]    store [LINES];

    assign push   = hc_valid_in && hc_ready_out && !hc_we_in;
    // A write on the reset edge is dropped along with everything else in flight.
    assign wr     = hc_valid_in && hc_ready_out && hc_we_in && !rst_in;
    assign wr_idx = hc_addr_in[OFF_W +: IDX_W];
    assign head_idx = head_req.paddr[OFF_W +: IDX_W];
    assign push_req.paddr = {hc_addr_in[PADDR_BITS-1:OFF_W], {OFF_W{1'b0}}};

    line_req_fifo #(
        .WIDTH ($bits(line_req_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_req_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .head      (head_req),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign q_count_nxt  = q_count + QC_W'(push) - QC_W'(pop);
    assign hc_valid_out = (state == RESP);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!q_empty) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_W'(LATENCY - 1);
                end
            end
            WAIT: begin
                // WAIT is only entered with a pending read, so the head is valid here.
                if (cnt == '0) begin
                    state_nxt = RESP;
                    pop       = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (hc_ready_in) begin
                    if (!q_empty) begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(LATENCY - 1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= IDLE;
            cnt          <= '0;
            hc_ready_out <= 1'b0;
            hc_addr_out  <= '0;
            hc_value_out <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            hc_ready_out <= (q_count_nxt != QC_W'(QUEUE_DEPTH));
            if (pop) begin
                hc_addr_out  <= head_req.paddr;
                // Forward a write-back landing on the same edge the line is captured.
                hc_value_out <= (wr && (wr_idx == head_idx)) ? hc_value_in : store[head_idx];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr) store[wr_idx] <= hc_value_in;
    end

`ifdef L1D_RESP_ALIGN_CHECK_EN
    logic err_q;
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            err_q <= 1'b0;
        end else if (push && (hc_addr_in[OFF_W-1:0] != '0)) begin
            err_q <= 1'b1;
        end
    end
    assign err_out = err_q;
`else
    assign err_out = 1'b0;
`endif

    // Offset bits and the FIFO full flag are intentionally not consumed in every build.
    logic unused_sink;
    assign unused_sink = ^{q_full, hc_addr_in[OFF_W-1:0]};
endmodule

// File: tb/tb_l1d_lower_responder.sv
// Randomized + directed bench for l1d_lower_responder against a transaction-timing model.
// Latency: n/a.
// Backpressure: exercised through hc_ready_in stalls and queue-full acceptance.
module tb_l1d_lower_responder;
    localparam int LAT   = 4;
    localparam int DEPTH = 4;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         hc_valid_in;
    logic         hc_ready_out;
    logic [21:0]  hc_addr_in;
    logic [511:0] hc_value_in;
    logic         hc_we_in;
    logic         hc_valid_out;
    logic         hc_ready_in;
    logic [21:0]  hc_addr_out;
    logic [511:0] hc_value_out;
    logic         err_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    l1d_lower_responder dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .hc_valid_in  (hc_valid_in),
        .hc_ready_out (hc_ready_out),
        .hc_addr_in   (hc_addr_in),
        .hc_value_in  (hc_value_in),
        .hc_we_in     (hc_we_in),
        .hc_valid_out (hc_valid_out),
        .hc_ready_in  (hc_ready_in),
        .hc_addr_out  (hc_addr_out),
        .hc_value_out (hc_value_out),
        .err_out      (err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each read is serviced one at a time; service of a read starts when the responder
    // is free (right away if the read was waiting, else the edge after it arrived) and its
    // line is captured LAT edges after service starts.
    logic [511:0] mstore [64];
    logic [21:0]  q_a [$];
    int           q_t [$];
    int           t = 0;
    int           free_edge = 0;
    int           next_resp = -1;
    logic         m_ready = 0, m_valid = 0, m_err = 0;
    logic [21:0]  m_addr = '0;
    logic [511:0] m_value = '0;

    always @(posedge clk_in) begin
        logic acc;
        t++;
        if (rst_in) begin
            q_a.delete();
            q_t.delete();
            m_ready = 0; m_valid = 0; m_err = 0; m_addr = '0; m_value = '0;
            free_edge = t;
            next_resp = -1;
        end else begin
            acc = hc_valid_in && m_ready;
            if (acc && hc_we_in) mstore[hc_addr_in[11:6]] = hc_value_in;
            if (next_resp == t) begin
                m_addr  = q_a[0];
                m_value = mstore[q_a[0][11:6]];
                m_valid = 1;
                void'(q_a.pop_front());
                void'(q_t.pop_front());
                next_resp = -1;
            end else if (m_valid && hc_ready_in) begin
                m_valid   = 0;
                free_edge = t;
            end
            if (acc && !hc_we_in) begin
                q_a.push_back({hc_addr_in[21:6], 6'b0});
                q_t.push_back(t);
`ifdef L1D_RESP_ALIGN_CHECK_EN
                if (hc_addr_in[5:0] != 6'd0) m_err = 1;
`endif
            end
            if (next_resp < 0 && !m_valid && q_a.size() > 0)
                next_resp = ((q_t[0] < free_edge) ? free_edge : q_t[0] + 1) + LAT;
            m_ready = (q_a.size() != DEPTH);
        end
    end

    // ---------------- compare + response monitor ----------------
    logic [21:0]  rq_a [$];
    logic [511:0] rq_v [$];

    always @(negedge clk_in) begin
        #2;
        if (chk_on) begin
            check("ready", 512'(hc_ready_out), 512'(m_ready));
            check("valid", 512'(hc_valid_out), 512'(m_valid));
            check("addr",  512'(hc_addr_out),  512'(m_addr));
            check("value", hc_value_out, m_value);
            check("err",   512'(err_out),      512'(m_err));
            if (hc_valid_out && hc_ready_in) begin
                rq_a.push_back(hc_addr_out);
                rq_v.push_back(hc_value_out);
            end
        end
    end

    // ---------------- drivers ----------------
    function automatic logic [511:0] rnd_line();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] rep(input logic [7:0] b);
        return {64{b}};
    endfunction

    task automatic send(input logic we, input logic [21:0] a, input logic [511:0] v);
        int n;
        @(negedge clk_in);
        hc_valid_in = 1; hc_we_in = we; hc_addr_in = a; hc_value_in = v;
        n = 0;
        while (!hc_ready_out && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: addr %0h not accepted within 200 cycles", a);
        end
        @(posedge clk_in);
    endtask

    task automatic idle();
        @(negedge clk_in);
        hc_valid_in = 0;
    endtask

    task automatic wait_resps(input int n);
        int c;
        c = 0;
        while (rq_a.size() < n && c < 300) begin
            @(negedge clk_in);
            c++;
        end
        if (rq_a.size() < n) begin
            n_checks++; n_fail++;
            $display("FAIL resp_timeout: got %0d responses expected %0d", rq_a.size(), n);
        end
        repeat (2) @(negedge clk_in);
    endtask

    initial begin
        int n;
        logic [21:0] ea [6];
        rst_in = 1; hc_valid_in = 0; hc_we_in = 0; hc_addr_in = '0;
        hc_value_in = '0; hc_ready_in = 1;
        repeat (3) @(negedge clk_in);
        check("rst_ready", 512'(hc_ready_out), 512'(0));
        check("rst_valid", 512'(hc_valid_out), 512'(0));
        check("rst_addr",  512'(hc_addr_out),  512'(0));
        check("rst_value", hc_value_out, 512'(0));
        check("rst_err",   512'(err_out), 512'(0));
        chk_on = 1;
        rst_in = 0;

        // Give every line a defined value.
        for (int i = 0; i < 64; i++) send(1, 22'(i * 64), rnd_line());
        idle();
        repeat (3) @(negedge clk_in);

        // Write-back then read: latency and data.
        rq_a.delete(); rq_v.delete();
        send(1, 22'h00040, rep(8'hA5));
        send(0, 22'h00040, '0);
        @(negedge clk_in);
        hc_valid_in = 0;
        n = 0;
        while (!hc_valid_out && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        check("rd_latency", 512'(n), 512'(5));
        wait_resps(1);
        check("wr_rd_addr",  512'(rq_a[0]), 512'(22'h00040));
        check("wr_rd_value", rq_v[0], rep(8'hA5));

        // Back-to-back reads in order.
        send(1, 22'h00000, rep(8'h11));
        send(1, 22'h00040, rep(8'h22));
        send(1, 22'h00080, rep(8'h33));
        rq_a.delete(); rq_v.delete();
        send(0, 22'h00000, '0);
        send(0, 22'h00040, '0);
        send(0, 22'h00080, '0);
        idle();
        wait_resps(3);
        check("b2b_0", rq_v[0], rep(8'h11));
        check("b2b_1", rq_v[1], rep(8'h22));
        check("b2b_2", rq_v[2], rep(8'h33));

        // Backpressure: queue fills while the response is held.
        for (int i = 0; i < 6; i++) begin
            ea[i] = 22'(32'h200 + i * 64);
            send(1, ea[i], rep(8'(8'h60 + i)));
        end
        idle();
        rq_a.delete(); rq_v.delete();
        hc_ready_in = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(0, ea[i], '0);
                idle();
            end
            begin
                repeat (20) @(negedge clk_in);
                check("bp_ready_low",  512'(hc_ready_out), 512'(0));
                check("bp_valid_held", 512'(hc_valid_out), 512'(1));
                hc_ready_in = 1;
            end
        join
        wait_resps(6);
        for (int i = 0; i < 6; i++) begin
            check("bp_order_addr",  512'(rq_a[i]), 512'(ea[i]));
            check("bp_order_value", rq_v[i], rep(8'(8'h60 + i)));
        end

        // Write-back two cycles after the read still reaches the response.
        send(1, 22'h00100, rep(8'h5A));
        idle();
        rq_a.delete(); rq_v.delete();
        send(0, 22'h00100, '0);
        idle();
        send(1, 22'h00100, rep(8'hFF));
        idle();
        wait_resps(1);
        check("hazard_value", rq_v[0], rep(8'hFF));

        // Reset mid-flight drops everything pending.
        hc_ready_in = 0;
        send(0, 22'h00000, '0);
        send(0, 22'h00040, '0);
        idle();
        rst_in = 1;
        @(negedge clk_in);
        rst_in = 0;
        @(negedge clk_in);
        check("post_rst_ready", 512'(hc_ready_out), 512'(1));
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (hc_valid_out) n++;
        end
        check("post_rst_no_valid", 512'(n), 512'(0));
        hc_ready_in = 1;

        // Misaligned read is serviced aligned.
        rq_a.delete(); rq_v.delete();
        send(0, 22'h00047, '0);
        idle();
`ifdef L1D_RESP_ALIGN_CHECK_EN
        check("misalign_err", 512'(err_out), 512'(1));
`else
        check("misalign_err", 512'(err_out), 512'(0));
`endif
        wait_resps(1);
        check("misalign_addr", 512'(rq_a[0]), 512'(22'h00040));

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_in);
            hc_valid_in = ($urandom_range(0, 99) < 60);
            hc_we_in    = ($urandom_range(0, 2) == 0);
            hc_addr_in  = 22'($urandom);
            hc_value_in = rnd_line();
            hc_ready_in = ($urandom_range(0, 3) != 0);
            rst_in      = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk_in);
        hc_valid_in = 0; hc_ready_in = 1; rst_in = 0;
        repeat (40) @(negedge clk_in);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
